// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: grants one host at a time and issues its transaction.
// It supports per-owner bursts and aborts a transaction after a response timeout.
module bus_arbiter_rr #(
  parameter int unsigned NrHosts       = 4,
  parameter int unsigned MaxBurst      = 4,
  parameter int unsigned TimeoutCycles = 16,
  localparam int unsigned SW = (NrHosts > 1) ? $clog2(NrHosts) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrHosts-1:0] host_req_i,
  output logic [NrHosts-1:0] host_gnt_o,
  output logic [NrHosts-1:0] host_rvalid_o,
  output logic [NrHosts-1:0] host_err_o,
  output logic               bus_req_o,
  output logic [SW-1:0]      bus_sel_o,
  input  logic               bus_rvalid_i,
  output logic               busy_o
);

  localparam int unsigned IW = SW + 1;
  localparam int unsigned TW = $clog2(TimeoutCycles);
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   w_ptr_nxt;
  logic [SW-1:0]   r_owner;
  logic [SW-1:0]   w_owner_nxt;
  logic [BW-1:0]   r_burst_cnt;
  logic [BW-1:0]   w_burst_cnt_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;

  logic            w_any;
  logic [SW-1:0]   w_sel;
  logic [IW-1:0]   w_idx;
  logic            w_timeout;

  // Round-robin search starting just after the last served host
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int unsigned i = 1; i <= NrHosts; i++) begin
      w_idx = {1'b0, r_ptr} + IW'(i);
      if (w_idx >= IW'(NrHosts)) begin
        w_idx = w_idx - IW'(NrHosts);
      end
      if (!w_any && host_req_i[w_idx[SW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[SW-1:0];
      end
    end
  end

  assign w_timeout = (r_timer == TW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_ptr       <= SW'(NrHosts - 1);
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  // Outputs are held low while reset is asserted so a reset mid-WAIT drops silently
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_timer_nxt     = r_timer;
    host_gnt_o      = '0;
    host_rvalid_o   = '0;
    host_err_o      = '0;
    bus_req_o       = 1'b0;
    bus_sel_o       = '0;
    busy_o          = 1'b0;

    if (!rst_i) begin
      busy_o = (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_owner_nxt     = w_sel;
            w_burst_cnt_nxt = '0;
            w_state_nxt     = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          bus_req_o           = 1'b1;
          bus_sel_o           = r_owner;
          host_gnt_o[r_owner] = 1'b1;
          w_timer_nxt         = '0;
          w_state_nxt         = ST_WAIT;
        end

        ST_WAIT: begin
          bus_sel_o   = r_owner;
          w_timer_nxt = w_timeout ? r_timer : r_timer + TW'(1);
          if (bus_rvalid_i) begin
            host_rvalid_o[r_owner] = 1'b1;
            w_ptr_nxt              = r_owner;
            if (host_req_i[r_owner] && (r_burst_cnt < BW'(MaxBurst - 1))) begin
              w_burst_cnt_nxt = r_burst_cnt + BW'(1);
              w_state_nxt     = ST_ISSUE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_timeout) begin
            host_err_o[r_owner] = 1'b1;
            w_ptr_nxt           = r_owner;
            w_state_nxt         = ST_IDLE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic checked
// every cycle against a transaction-level reference model.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 16;

  logic         clk;
  logic         rst;
  logic [N-1:0] host_req;
  logic [N-1:0] host_gnt;
  logic [N-1:0] host_rvalid;
  logic [N-1:0] host_err;
  logic         bus_req;
  logic [1:0]   bus_sel;
  logic         bus_rvalid;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: phase 0 = idle, 1 = granting, 2 = waiting for the device
  int m_phase, m_owner, m_last, m_run, m_waited;

  logic [N-1:0] e_gnt, e_rv, e_err;
  logic         e_breq, e_busy;
  logic [1:0]   e_sel;
  logic [N-1:0] s_gnt, s_rv, s_err;
  logic         s_breq, s_busy;
  logic [1:0]   s_sel;

  bus_arbiter_rr #(
    .NrHosts      (N),
    .MaxBurst     (MB),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .host_req_i   (host_req),
    .host_gnt_o   (host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_err_o   (host_err),
    .bus_req_o    (bus_req),
    .bus_sel_o    (bus_sel),
    .bus_rvalid_i (bus_rvalid),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    e_gnt = '0; e_rv = '0; e_err = '0; e_breq = 1'b0; e_busy = 1'b0; e_sel = '0;
    if (!rst) begin
      if (m_phase == 1) begin
        e_gnt  = N'(1) << m_owner;
        e_breq = 1'b1;
        e_sel  = 2'(m_owner);
        e_busy = 1'b1;
      end else if (m_phase == 2) begin
        e_sel  = 2'(m_owner);
        e_busy = 1'b1;
        if (bus_rvalid) e_rv = N'(1) << m_owner;
        else if (m_waited == TO) e_err = N'(1) << m_owner;
      end
    end
  endtask

  task automatic model_update();
    bit found;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_owner = 0; m_run = 0; m_waited = 0;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && host_req[(m_last + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_last + k) % N;
        end
      end
      if (found) begin
        m_run   = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase  = 2;
      m_waited = 1;
    end else begin
      if (bus_rvalid) begin
        m_last = m_owner;
        if (host_req[m_owner] && m_run < MB) begin
          m_run++;
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end else if (m_waited == TO) begin
        m_last  = m_owner;
        m_phase = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  // One clock cycle: apply inputs, compare mid-cycle, advance model after the edge
  task automatic run_cycle(input logic r, input logic [N-1:0] req, input logic rv);
    rst = r; host_req = req; bus_rvalid = rv;
    #2;
    model_outputs();
    s_gnt = host_gnt; s_rv = host_rvalid; s_err = host_err;
    s_breq = bus_req; s_sel = bus_sel; s_busy = busy;
    chk("gnt",     32'(s_gnt),  32'(e_gnt));
    chk("rvalid",  32'(s_rv),   32'(e_rv));
    chk("err",     32'(s_err),  32'(e_err));
    chk("bus_req", 32'(s_breq), 32'(e_breq));
    chk("bus_sel", 32'(s_sel),  32'(e_sel));
    chk("busy",    32'(s_busy), 32'(e_busy));
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    run_cycle(1'b1, '0, 1'b0);
    run_cycle(1'b1, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] gq[$];
    logic [N-1:0] exp_order[5];
    logic [N-1:0] req, pending;
    logic         r, rv;

    rst = 1'b1; host_req = '0; bus_rvalid = 1'b0;
    m_phase = 0; m_last = N - 1; m_owner = 0; m_run = 0; m_waited = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy", 32'(s_busy), 32'(0));

    // Two-cycle grant latency with host 1 winning from reset pointer
    run_cycle(1'b0, 4'b1010, 1'b0);
    chk("r029_c1_gnt", 32'(s_gnt), 32'(0));
    run_cycle(1'b0, 4'b1010, 1'b0);
    chk("r029_gnt", 32'(s_gnt), 32'(4'b0010));
    chk("r029_sel", 32'(s_sel), 32'(1));
    chk("r029_breq", 32'(s_breq), 32'(1));
    run_cycle(1'b0, 4'b1000, 1'b1);
    chk("r029_rv", 32'(s_rv), 32'(4'b0010));
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 4'b0000, 1'b1);

    // Fair rotation when everyone keeps requesting except at its own response
    do_reset();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int c = 0; c < 60 && gq.size() < 5; c++) begin
      req = 4'hF;
      if (m_phase == 2) req[m_owner] = 1'b0;
      run_cycle(1'b0, req, m_phase == 2);
      if (s_gnt != '0) gq.push_back(s_gnt);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("r030_order%0d", i), 32'((i < gq.size()) ? gq[i] : '0), 32'(exp_order[i]));
    end

    // Burst of MaxBurst to a lone requester, one idle cycle, then re-grant
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      run_cycle(1'b0, 4'b0100, 1'b1);
      chk($sformatf("r031_gnt_c%0d", c), 32'(s_gnt),
          32'((c == 2 || c == 4 || c == 6 || c == 8 || c == 11) ? 4'b0100 : 4'b0000));
      if (c == 10) chk("r031_idle_busy", 32'(s_busy), 32'(0));
    end

    // Timeout on the 16th WAIT cycle
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      run_cycle(1'b0, (c <= 2) ? 4'b0010 : 4'b0000, 1'b0);
      if (c == 17) chk("r032_err_early", 32'(s_err), 32'(0));
      if (c == 18) chk("r032_err", 32'(s_err), 32'(4'b0010));
      if (c == 19) begin
        chk("r032_err_after", 32'(s_err), 32'(0));
        chk("r032_busy", 32'(s_busy), 32'(0));
      end
    end

    // Response on the timeout cycle wins
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      run_cycle(1'b0, (c <= 2) ? 4'b0010 : 4'b0000, c == 18);
      if (c == 18) begin
        chk("r033_rv", 32'(s_rv), 32'(4'b0010));
        chk("r033_err", 32'(s_err), 32'(0));
      end
    end

    // Reset mid-WAIT for host 3, then lowest-index requester wins
    do_reset();
    run_cycle(1'b0, 4'b1000, 1'b0);
    run_cycle(1'b0, 4'b1000, 1'b0);
    chk("r034_gnt3", 32'(s_gnt), 32'(4'b1000));
    run_cycle(1'b0, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 4'b0000, 1'b1);
    run_cycle(1'b0, 4'b1010, 1'b1);
    chk("r034_busy", 32'(s_busy), 32'(0));
    chk("r034_rv", 32'(s_rv), 32'(0));
    chk("r034_sel", 32'(s_sel), 32'(0));
    run_cycle(1'b0, 4'b1010, 1'b0);
    chk("r034_regrant", 32'(s_gnt), 32'(4'b0010));

    // Random traffic against the reference model
    do_reset();
    pending = '0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 399) == 0);
      pending = pending | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      rv = ($urandom_range(0, 5) == 0);
      run_cycle(r, pending, rv);
      if (e_gnt != '0 && $urandom_range(0, 1) == 1) pending = pending & ~e_gnt;
      if (r) pending = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NrHosts, default 4, number of requesting hosts (2..16).
REQ-002 SHALL have parameter MaxBurst, default 4, maximum back-to-back transactions granted to one host before re-arbitration (1..15).
REQ-003 SHALL have parameter TimeoutCycles, default 16, maximum WAIT cycles before a transaction is aborted (2..255).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port host_req_i  input  NrHosts  per-host transaction request, level, held until granted.
REQ-007 SHALL have port host_gnt_o  output  NrHosts  one-hot grant, one-cycle pulse per accepted transaction.
REQ-008 SHALL have port host_rvalid_o  output  NrHosts  one-hot response-valid to the owning host.
REQ-009 SHALL have port host_err_o  output  NrHosts  one-hot timeout-error pulse to the owning host.
REQ-010 SHALL have port bus_req_o  output  1  transaction issue strobe toward the bus.
REQ-011 SHALL have port bus_sel_o  output  SW=max(1,$clog2(NrHosts))  index of the host driving the bus.
REQ-012 SHALL have port bus_rvalid_i  input  1  device response completion from the bus.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, ISSUE, WAIT.
REQ-015 IDLE: if any host_req_i bit set, SHALL select owner by round-robin, searching ptr+1, ptr+2, ... modulo NrHosts; register owner, clear burst_cnt, go ISSUE; else stay IDLE.
REQ-016 ISSUE (exactly one cycle): SHALL drive bus_req_o=1, host_gnt_o[owner]=1, clear timer, go WAIT.
REQ-017 bus_sel_o SHALL equal owner in ISSUE and WAIT, and 0 in IDLE.
REQ-018 WAIT: timer SHALL increment by 1 per cycle, saturating at TimeoutCycles-1.
REQ-019 WAIT with bus_rvalid_i=1: SHALL drive host_rvalid_o[owner]=1 combinationally in that cycle; set ptr=owner.
REQ-020 On that response: if host_req_i[owner]=1 and burst_cnt<MaxBurst-1, SHALL increment burst_cnt and go ISSUE with same owner (no idle cycle); otherwise go IDLE.
REQ-021 WAIT with bus_rvalid_i=0 and timer==TimeoutCycles-1: SHALL pulse host_err_o[owner] for one cycle, set ptr=owner, go IDLE.
REQ-022 Response and timeout in same cycle: response SHALL win; no error pulse.
REQ-023 bus_rvalid_i in IDLE or ISSUE SHALL be ignored; no host_rvalid_o generated.
REQ-024 Request deassertion by owner during WAIT SHALL NOT abort the transaction.
REQ-025 At most one bit of host_gnt_o, host_rvalid_o, host_err_o SHALL be set in any cycle.
REQ-026 Minimum latency request-to-grant from IDLE SHALL be 2 cycles (IDLE sample, ISSUE grant).

Reset
REQ-027 rst_i=1 SHALL force state IDLE, ptr=NrHosts-1 (host 0 first priority), owner=0, burst_cnt=0, timer=0, in the same clock edge.
REQ-028 During and after reset all outputs SHALL be 0 until first arbitration; reset mid-WAIT SHALL drop the transaction with no rvalid/err pulse.

Verification
REQ-029 After reset, host_req_i=4'b1010 -> cycle 2 host_gnt_o=4'b0010, bus_sel_o=1, bus_req_o=1.
REQ-030 All four hosts request continuously, MaxBurst=1, rvalid 1 cycle after each ISSUE -> grant order 0,1,2,3,0 with no host granted twice before all others.
REQ-031 Host 2 alone requesting continuously, MaxBurst=4 -> exactly 4 grants to host 2 with no IDLE between, then IDLE, then re-granted to host 2.
REQ-032 Grant host 1, bus_rvalid_i never asserted, TimeoutCycles=16 -> host_err_o=4'b0010 for one cycle on 16th WAIT cycle, then IDLE, busy_o=0.
REQ-033 bus_rvalid_i=1 on exactly the 16th WAIT cycle -> host_rvalid_o pulse, host_err_o stays 0.
REQ-034 rst_i asserted in WAIT for host 3 -> next cycle state IDLE, all outputs 0, next grant goes to lowest-index requester.
